// File: rtl/ccr_controller_pkg.sv
// Shared types and constants for the condition-code register controller.
// State encodings, flag bit positions and the CCR width.
package ccr_controller_pkg;

    localparam int CCR_W = 4;

    // Flag positions inside the CCR word {NF,OF,CF,ZF}
    localparam int FLAG_ZF = 0;
    localparam int FLAG_CF = 1;
    localparam int FLAG_OF = 2;
    localparam int FLAG_NF = 3;

    typedef enum logic [1:0] {
        CCR_RUN   = 2'd0,
        CCR_SAVE  = 2'd1,
        CCR_FLUSH = 2'd2
    } ccr_state_e;

endpackage

// File: rtl/ccr_controller_if.sv
// Execute-stage side of the CCR controller.
// The master drives pipeline events; the slave returns flags and status.
interface ccr_controller_if #(parameter int CNT_W = 3) ();
    import ccr_controller_pkg::*;

    logic             ex_valid;
    logic             stall;
    logic [CCR_W-1:0] flags_in;
    logic             rti_commit;
    logic             int_req;
    logic             flush_done;
    logic [CCR_W-1:0] ccr;
    logic [CCR_W-1:0] freezed_ccr;
    logic             int_ack;
    logic             int_blocked;
    logic             rti_underflow;
    logic [CNT_W-1:0] depth;

    modport master (
        output ex_valid, stall, flags_in, rti_commit, int_req, flush_done,
        input  ccr, freezed_ccr, int_ack, int_blocked, rti_underflow, depth
    );

    modport slave (
        input  ex_valid, stall, flags_in, rti_commit, int_req, flush_done,
        output ccr, freezed_ccr, int_ack, int_blocked, rti_underflow, depth
    );
endinterface

// File: rtl/ccr_controller_stack.sv
// LIFO of saved CCR copies. Push is ignored when full and pop when empty,
// so the depth can never wrap. Popped slots are cleared.
module ccr_stack
    import ccr_controller_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [CCR_W-1:0] push_data,
    output logic [CCR_W-1:0] top,
    output logic [CNT_W-1:0] depth,
    output logic             full,
    output logic             empty
);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CCR_W-1:0] entries_r [DEPTH];
    logic [CNT_W-1:0] depth_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (depth_r == CNT_W'(DEPTH));
    assign empty     = (depth_r == {CNT_W{1'b0}});
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;
    assign depth     = depth_r;

    // Entry storage and occupancy counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_r[i] <= {CCR_W{1'b0}};
            end
            depth_r <= {CNT_W{1'b0}};
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (do_push_s && (depth_r == CNT_W'(i))) begin
                    entries_r[i] <= push_data;
                end else if (do_pop_s && (depth_r == CNT_W'(i + 1))) begin
                    entries_r[i] <= {CCR_W{1'b0}};
                end else begin
                    entries_r[i] <= entries_r[i];
                end
            end
            if (do_push_s) begin
                depth_r <= depth_r + CNT_ONE;
            end else if (do_pop_s) begin
                depth_r <= depth_r - CNT_ONE;
            end else begin
                depth_r <= depth_r;
            end
        end
    end

    // Top-of-stack select; reads zero when nothing is saved
    always_comb begin
        top = {CCR_W{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            if (depth_r == CNT_W'(i + 1)) begin
                top = entries_r[i];
            end else begin
                top = top;
            end
        end
    end
endmodule

// File: rtl/ccr_controller.sv
// Condition-code register with interrupt save/restore. The push happens on
// the RUN->SAVE edge, so depth, freezed_ccr and int_ack all appear in SAVE.
module ccr_controller
    import ccr_controller_pkg::*;
#(
    parameter int NEST_DEPTH = 2,
    parameter int CNT_W      = 3
) (
    input  logic            clk,
    input  logic            rst,
    ccr_controller_if.slave bus
);
    ccr_state_e       state_r, state_s;
    logic [CCR_W-1:0] ccr_r, ccr_s;
    logic             int_ack_r;
    logic             rti_underflow_r, underflow_s;
    logic             capture_s;
    logic             push_s, pop_s;
    logic [CCR_W-1:0] push_data_s;
    logic [CCR_W-1:0] top_s;
    logic             full_s, empty_s;

    ccr_stack #(.DEPTH(NEST_DEPTH), .CNT_W(CNT_W)) u_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .pop       (pop_s),
        .push_data (push_data_s),
        .top       (top_s),
        .depth     (bus.depth),
        .full      (full_s),
        .empty     (empty_s)
    );

    assign capture_s       = bus.ex_valid & ~bus.stall & (state_r == CCR_RUN);
    assign bus.ccr         = ccr_r;
    assign bus.freezed_ccr = top_s;
    assign bus.int_ack     = int_ack_r;
    assign bus.int_blocked = bus.int_req & full_s;
    assign bus.rti_underflow = rti_underflow_r;

    // Next state, CCR update and stack control
    always_comb begin
        state_s     = state_r;
        ccr_s       = ccr_r;
        push_s      = 1'b0;
        pop_s       = 1'b0;
        push_data_s = ccr_r;
        underflow_s = 1'b0;
        case (state_r)
            CCR_RUN: begin
                if (capture_s) begin
                    ccr_s = bus.flags_in;
                end else begin
                    ccr_s = ccr_r;
                end
                // RTI beats a coincident interrupt; the restore beats capture
                if (bus.rti_commit) begin
                    if (!empty_s) begin
                        ccr_s = top_s;
                        pop_s = 1'b1;
                    end else begin
                        underflow_s = 1'b1;
                    end
                end else if (bus.int_req && !full_s) begin
                    state_s     = CCR_SAVE;
                    push_s      = 1'b1;
                    push_data_s = capture_s ? bus.flags_in : ccr_r;
                end else begin
                    state_s = CCR_RUN;
                end
            end
            CCR_SAVE: begin
                state_s = CCR_FLUSH;
            end
            CCR_FLUSH: begin
                if (bus.flush_done) begin
                    state_s = CCR_RUN;
                end else begin
                    state_s = CCR_FLUSH;
                end
            end
            default: begin
                state_s = CCR_RUN;
            end
        endcase
    end

    // State, CCR and registered status pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r         <= CCR_RUN;
            ccr_r           <= {CCR_W{1'b0}};
            int_ack_r       <= 1'b0;
            rti_underflow_r <= 1'b0;
        end else begin
            state_r         <= state_s;
            ccr_r           <= ccr_s;
            int_ack_r       <= push_s;
            rti_underflow_r <= underflow_s;
        end
    end
endmodule

// File: tb/tb_ccr_controller.sv
// Directed bench for ccr_controller: capture, nested save/restore,
// full-stack blocking, RTI underflow, RTI/interrupt collision, async reset.
module tb_ccr_controller;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    ccr_controller_if #(.CNT_W(3)) bus ();

    ccr_controller #(.NEST_DEPTH(2), .CNT_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        bus.ex_valid   = 1'b0;
        bus.stall      = 1'b0;
        bus.flags_in   = 4'b0000;
        bus.rti_commit = 1'b0;
        bus.int_req    = 1'b0;
        bus.flush_done = 1'b0;
        tick();
        tick();
        check("rst_ccr",   {4'b0, bus.ccr}, 8'h00);
        check("rst_depth", {5'b0, bus.depth}, 8'h00);
        check("rst_frz",   {4'b0, bus.freezed_ccr}, 8'h00);
        check("rst_ack",   {7'b0, bus.int_ack}, 8'h00);
        check("rst_uflow", {7'b0, bus.rti_underflow}, 8'h00);
        rst = 1'b1;

        // Captures with one-cycle lag
        bus.ex_valid = 1'b1; bus.flags_in = 4'b0001;
        tick();
        check("cap1", {4'b0, bus.ccr}, 8'h01);
        bus.flags_in = 4'b1000;
        check("cap2_lag", {4'b0, bus.ccr}, 8'h01);
        tick();
        check("cap2", {4'b0, bus.ccr}, 8'h08);
        bus.flags_in = 4'b0110;
        tick();
        check("cap3", {4'b0, bus.ccr}, 8'h06);
        bus.stall = 1'b1; bus.flags_in = 4'b1111;
        tick();
        check("stall_hold", {4'b0, bus.ccr}, 8'h06);
        bus.stall = 1'b0;

        // Single interrupt entry
        bus.flags_in = 4'b0101;
        tick();
        bus.ex_valid = 1'b0; bus.int_req = 1'b1;
        tick();
        check("save_ack",   {7'b0, bus.int_ack}, 8'h01);
        check("save_depth", {5'b0, bus.depth}, 8'h01);
        check("save_frz",   {4'b0, bus.freezed_ccr}, 8'h05);
        bus.int_req = 1'b0; bus.ex_valid = 1'b1; bus.flags_in = 4'b1111;
        tick();
        check("flush_ack",   {7'b0, bus.int_ack}, 8'h00);
        check("save_nocap",  {4'b0, bus.ccr}, 8'h05);
        tick();
        check("flush_nocap", {4'b0, bus.ccr}, 8'h05);
        bus.flush_done = 1'b1;
        tick();
        check("flush_exit_nocap", {4'b0, bus.ccr}, 8'h05);
        bus.flush_done = 1'b0;

        // Second nesting level: capture and interrupt in the same cycle
        bus.flags_in = 4'b0011; bus.int_req = 1'b1;
        tick();
        check("nest_ack",   {7'b0, bus.int_ack}, 8'h01);
        check("nest_depth", {5'b0, bus.depth}, 8'h02);
        check("nest_frz",   {4'b0, bus.freezed_ccr}, 8'h03);
        check("nest_ccr",   {4'b0, bus.ccr}, 8'h03);
        bus.int_req = 1'b0; bus.ex_valid = 1'b0; bus.flush_done = 1'b1;
        tick();
        bus.rti_commit = 1'b1;
        tick();
        bus.rti_commit = 1'b0; bus.flush_done = 1'b0;
        check("flush_rti_ignored", {5'b0, bus.depth}, 8'h02);

        // Full stack blocks a third request
        bus.int_req = 1'b1;
        #1;
        check("blocked", {7'b0, bus.int_blocked}, 8'h01);
        tick();
        check("blocked_noack", {7'b0, bus.int_ack}, 8'h00);
        check("blocked_depth", {5'b0, bus.depth}, 8'h02);
        bus.int_req = 1'b0;
        #1;
        check("unblocked", {7'b0, bus.int_blocked}, 8'h00);

        // Restores override capture
        bus.rti_commit = 1'b1; bus.ex_valid = 1'b1; bus.flags_in = 4'b1110;
        tick();
        check("rti1_ccr",   {4'b0, bus.ccr}, 8'h03);
        check("rti1_depth", {5'b0, bus.depth}, 8'h01);
        check("rti1_frz",   {4'b0, bus.freezed_ccr}, 8'h05);
        tick();
        check("rti2_ccr",   {4'b0, bus.ccr}, 8'h05);
        check("rti2_depth", {5'b0, bus.depth}, 8'h00);
        check("rti2_frz",   {4'b0, bus.freezed_ccr}, 8'h00);
        check("rti2_uflow", {7'b0, bus.rti_underflow}, 8'h00);

        // Underflow: normal capture, one-cycle pulse
        bus.flags_in = 4'b0010;
        tick();
        check("uflow_pulse", {7'b0, bus.rti_underflow}, 8'h01);
        check("uflow_ccr",   {4'b0, bus.ccr}, 8'h02);
        check("uflow_depth", {5'b0, bus.depth}, 8'h00);
        bus.rti_commit = 1'b0; bus.ex_valid = 1'b0;
        tick();
        check("uflow_clear", {7'b0, bus.rti_underflow}, 8'h00);

        // Save 1001, then collide RTI with int_req
        bus.ex_valid = 1'b1; bus.flags_in = 4'b1001;
        tick();
        bus.ex_valid = 1'b0; bus.int_req = 1'b1;
        tick();
        bus.int_req = 1'b0; bus.flush_done = 1'b1;
        tick();
        tick();
        bus.flush_done = 1'b0;
        bus.ex_valid = 1'b1; bus.flags_in = 4'b0100;
        tick();
        check("pre_coll_ccr", {4'b0, bus.ccr}, 8'h04);
        bus.ex_valid = 1'b0; bus.rti_commit = 1'b1; bus.int_req = 1'b1;
        tick();
        check("coll_ccr",   {4'b0, bus.ccr}, 8'h09);
        check("coll_depth", {5'b0, bus.depth}, 8'h00);
        check("coll_noack", {7'b0, bus.int_ack}, 8'h00);
        bus.rti_commit = 1'b0;
        tick();
        check("coll_save_ack",   {7'b0, bus.int_ack}, 8'h01);
        check("coll_save_depth", {5'b0, bus.depth}, 8'h01);
        check("coll_save_frz",   {4'b0, bus.freezed_ccr}, 8'h09);

        // Reach FLUSH at depth 2, then assert reset between edges
        bus.int_req = 1'b0; bus.flush_done = 1'b1;
        tick();
        tick();
        bus.flush_done = 1'b0; bus.int_req = 1'b1;
        tick();
        bus.int_req = 1'b0;
        tick();
        check("pre_rst_depth", {5'b0, bus.depth}, 8'h02);
        #2;
        rst = 1'b0;
        #1;
        check("arst_ccr",   {4'b0, bus.ccr}, 8'h00);
        check("arst_depth", {5'b0, bus.depth}, 8'h00);
        check("arst_frz",   {4'b0, bus.freezed_ccr}, 8'h00);
        check("arst_ack",   {7'b0, bus.int_ack}, 8'h00);
        rst = 1'b1;
        bus.ex_valid = 1'b1; bus.flags_in = 4'b0111;
        tick();
        check("arst_run_cap", {4'b0, bus.ccr}, 8'h07);
        bus.ex_valid = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ccr_controller.md
Name: ccr_controller

Overview:
Owns the condition-code register (CCR) that feeds the ALU's flag inputs and its freezed_ccr restore input. Captures ALU flag outputs on every valid execute cycle. Saves the CCR into a small LIFO on interrupt entry and pops it back when an RTI commits. Sequences interrupt entry with a 3-state FSM so that squashed instructions cannot corrupt the flags.

Parameters:
NEST_DEPTH, 2, maximum number of nested saved CCR copies (LIFO entries); legal range 1..7.
CNT_W, 3, width of the depth counter; must satisfy 2^CNT_W > NEST_DEPTH.

Ports:
clk  in  1  core clock, rising edge.
rst  in  1  asynchronous, active-low reset.
ex_valid  in  1  execute stage holds a real (non-bubble) instruction this cycle.
stall  in  1  execute stage frozen; no CCR capture.
flags_in  in  4  ALU flag outputs {NF,OF,CF,ZF} (bit 3..0).
rti_commit  in  1  RTI instruction committing in execute this cycle.
int_req  in  1  level interrupt request, already synchronised.
flush_done  in  1  pipeline squash after interrupt entry complete.
ccr  out  4  current flags to the ALU {NF,OF,CF,ZF}.
freezed_ccr  out  4  top-of-stack saved flags; 4'b0 when the stack is empty.
int_ack  out  1  one-cycle pulse: interrupt accepted and CCR saved.
int_blocked  out  1  int_req high while the stack is full.
rti_underflow  out  1  one-cycle pulse: RTI committed with an empty stack.
depth  out  CNT_W  number of saved entries.

Behaviour:
- Reset (rst=0, asynchronous): ccr=0, stack entries=0, depth=0, FSM=RUN, int_ack=0, rti_underflow=0.
- capture = ex_valid & ~stall & (state==RUN). On capture, ccr <= flags_in at the next edge (one-cycle latency). The ALU already passes through unaffected flags, so there is no per-op masking here.
- FSM states are RUN, SAVE, FLUSH.
- RUN -> SAVE when int_req & (depth<NEST_DEPTH) & ~rti_commit.
- SAVE lasts 1 cycle:
  - push value = flags_in if capture happened in the entering cycle, else ccr (the newest flags are always saved);
  - depth++;
  - int_ack=1;
  - no capture.
- SAVE -> FLUSH unconditionally.
- FLUSH: no capture, and rti_commit is ignored (squashed). Go to RUN on flush_done. If flush_done is already high on entry, leave after 1 cycle.
- RTI, in RUN only:
  - if depth>0: ccr <= freezed_ccr (the restore overrides any capture that cycle), pop, depth--;
  - if depth==0: ccr follows normal capture, rti_underflow pulses 1 cycle, depth stays 0.
- Simultaneous rti_commit & int_req in RUN: RTI wins. The interrupt is taken the next cycle if still requested, and saves the restored CCR.
- Stack full (depth==NEST_DEPTH): int_req is not accepted and int_blocked = int_req (combinational); FSM stays in RUN.
- freezed_ccr is combinational from the top entry. Popped entries are cleared to 0.
- Depth never wraps. Pushes are guarded by full, pops by empty.
- Reset asserted mid-SAVE/FLUSH: immediate return to reset values; the saved stack is discarded.

Decomposition:
- defines.v: FSM encodings (CCR_RUN, CCR_SAVE, CCR_FLUSH), flag bit indices (FLAG_ZF=0, FLAG_CF=1, FLAG_OF=2, FLAG_NF=3), reuse of the existing ALU_RTI code for the decode that produces rti_commit.
- One sub-module, ccr_stack: a parameterised 4-bit LIFO with push, pop, top, depth, full and empty. The controller holds the FSM and the CCR register.

Test Plan:
- Reset then 3 valid captures of flags_in=4'b0001, 4'b1000, 4'b0110 -> ccr follows with 1-cycle lag, ending at 4'b0110; stall=1 holds ccr.
- ccr=4'b0101, int_req=1 -> SAVE next cycle with int_ack=1, depth=1, freezed_ccr=4'b0101; flags_in=4'b1111 during FLUSH is not captured; RUN after flush_done.
- Two nested interrupts (NEST_DEPTH=2) saving 4'b0101 then 4'b0011; a third int_req -> int_blocked=1, no ack; rti_commit -> ccr=4'b0011, depth=1; rti_commit -> ccr=4'b0101, depth=0.
- rti_commit with depth=0 and flags_in=4'b0010 -> rti_underflow pulse, ccr=4'b0010, depth=0.
- rti_commit and int_req in the same cycle with depth=1 and saved value 4'b1001 -> ccr=4'b1001, depth=0; next cycle SAVE pushes 4'b1001 and depth=1.
- rst driven low during FLUSH with depth=2 -> ccr=0, depth=0, freezed_ccr=0, FSM=RUN immediately, without waiting for a clock edge.
